// File: rtl/byte_striping.sv
// Two-lane byte striper: alternates an input byte stream onto stripe 0/1 lanes
// that update every second clock, with an idle-timer flush for a lone stripe-0 byte.
module byte_striping #(
  parameter int DATA_WIDTH   = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_stripe_0,
  output logic [DATA_WIDTH-1:0] data_stripe_1,
  output logic                  valid_stripe_0,
  output logic                  valid_stripe_1
);

  localparam logic [3:0] FLUSH_LIM = 4'(FLUSH_CYCLES);

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    if (cnt >= FLUSH_LIM) return FLUSH_LIM;
    else                  return cnt + 4'd1;
  endfunction

  logic                  phase_p0;
  logic                  sel_p0;
  logic [DATA_WIDTH-1:0] f0_p0;
  logic                  vld_f0_p0;
  logic [3:0]            idle_cnt_p0;

  logic [DATA_WIDTH-1:0] b0_p1;
  logic [DATA_WIDTH-1:0] b1_p1;
  logic                  vld_b0_p1;
  logic                  vld_b1_p1;
  logic                  vld_buf_p1;

  logic                  update_edge;
  logic                  pair_done;
  logic [3:0]            cnt_inc;
  logic                  flush;
  logic                  load;

  always_comb begin
    update_edge = phase_p0;
    pair_done   = valid_in && sel_p0;
    cnt_inc     = sat_inc(idle_cnt_p0);
    // A byte arriving on the threshold cycle completes the pair instead of flushing.
    flush       = vld_f0_p0 && !valid_in && (cnt_inc == FLUSH_LIM) &&
                  (!vld_buf_p1 || update_edge);
    load        = pair_done || flush;
  end

  // Stage p0 -> p1: pair forming and idle timer control
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      phase_p0       <= 1'b0;
      sel_p0         <= 1'b0;
      vld_f0_p0      <= 1'b0;
      idle_cnt_p0    <= 4'd0;
      vld_buf_p1     <= 1'b0;
      vld_b0_p1      <= 1'b0;
      vld_b1_p1      <= 1'b0;
      valid_stripe_0 <= 1'b0;
      valid_stripe_1 <= 1'b0;
      data_stripe_0  <= '0;
      data_stripe_1  <= '0;
    end else begin
      phase_p0 <= !phase_p0;

      if (load) begin
        sel_p0    <= 1'b0;
        vld_f0_p0 <= 1'b0;
      end else if (valid_in) begin
        sel_p0    <= 1'b1;
        vld_f0_p0 <= 1'b1;
      end

      if (valid_in || !vld_f0_p0 || flush) idle_cnt_p0 <= 4'd0;
      else                                 idle_cnt_p0 <= cnt_inc;

      vld_buf_p1 <= load || (vld_buf_p1 && !update_edge);
      if (load) begin
        vld_b0_p1 <= 1'b1;
        vld_b1_p1 <= pair_done;
      end

      // Stage p1 -> lanes: half-rate presentation, data holds when nothing is ready
      if (update_edge) begin
        if (vld_buf_p1) begin
          data_stripe_0  <= b0_p1;
          data_stripe_1  <= b1_p1;
          valid_stripe_0 <= vld_b0_p1;
          valid_stripe_1 <= vld_b1_p1;
        end else begin
          valid_stripe_0 <= 1'b0;
          valid_stripe_1 <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_2f) begin
    if (valid_in && !sel_p0) f0_p0 <= data_in;
    if (load) begin
      b0_p1 <= f0_p0;
      b1_p1 <= pair_done ? data_in : '0;
    end
  end

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping: reset, aligned/odd streams, flush, no-flush and mid-pair reset.
module tb_byte_striping;

  logic       clk_2f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] data_stripe_0;
  logic [7:0] data_stripe_1;
  logic       valid_stripe_0;
  logic       valid_stripe_1;

  int n_checks = 0;
  int n_errors = 0;

  byte_striping #(.DATA_WIDTH(8), .FLUSH_CYCLES(4)) dut (
    .clk_2f         (clk_2f),
    .reset          (reset),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .data_stripe_0  (data_stripe_0),
    .data_stripe_1  (data_stripe_1),
    .valid_stripe_0 (valid_stripe_0),
    .valid_stripe_1 (valid_stripe_1)
  );

  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_lanes(input string tag, input logic v0, input logic v1,
                             input logic [7:0] d0, input logic [7:0] d1);
    check({tag, "_v0"}, 32'(valid_stripe_0), 32'(v0));
    check({tag, "_v1"}, 32'(valid_stripe_1), 32'(v1));
    check({tag, "_d0"}, 32'(data_stripe_0), 32'(d0));
    check({tag, "_d1"}, 32'(data_stripe_1), 32'(d1));
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic do_reset(input int n, input logic v, input logic [7:0] d);
    reset    = 1'b1;
    valid_in = v;
    data_in  = d;
    repeat (n) @(posedge clk_2f);
    #1;
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
  endtask

  // Ten bytes 00..09 starting 'offset' cycles after reset release.
  task automatic run_stream(input int offset);
    int p;
    do_reset(2, 1'b0, 8'h00);
    for (int j = 1; j <= 16; j++) begin
      if (j > offset && j <= offset + 10) step(1'b1, 8'(j - 1 - offset));
      else                                step(1'b0, 8'h00);
      if (j >= 4 && j <= 13) begin
        p = (j - 4) / 2;
        check_lanes($sformatf("stream%0d_e%0d", offset, j), 1'b1, 1'b1,
                    8'(2 * p), 8'(2 * p + 1));
      end else begin
        check($sformatf("stream%0d_e%0d_v0", offset, j), 32'(valid_stripe_0), 32'd0);
        check($sformatf("stream%0d_e%0d_v1", offset, j), 32'(valid_stripe_1), 32'd0);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;

    // Reset held with traffic on the input
    do_reset(3, 1'b1, 8'hFF);
    check_lanes("rst", 1'b0, 1'b0, 8'h00, 8'h00);
    for (int j = 1; j <= 6; j++) begin
      step(1'b0, 8'h00);
      check_lanes($sformatf("rst_idle%0d", j), 1'b0, 1'b0, 8'h00, 8'h00);
    end

    run_stream(0);
    run_stream(1);

    // Pair A5,5A then lone C3 flushed after 4 idle cycles, then 11,22
    do_reset(2, 1'b0, 8'h00);
    step(1'b1, 8'hA5); check_lanes("fl_e1", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h5A); check_lanes("fl_e2", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 8'hC3); check_lanes("fl_e3", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00); check_lanes("fl_e4", 1'b1, 1'b1, 8'hA5, 8'h5A);
    step(1'b0, 8'h00); check_lanes("fl_e5", 1'b1, 1'b1, 8'hA5, 8'h5A);
    step(1'b0, 8'h00); check_lanes("fl_e6", 1'b0, 1'b0, 8'hA5, 8'h5A);
    step(1'b0, 8'h00); check_lanes("fl_e7", 1'b0, 1'b0, 8'hA5, 8'h5A);
    step(1'b0, 8'h00); check_lanes("fl_e8", 1'b1, 1'b0, 8'hC3, 8'h00);
    step(1'b1, 8'h11); check_lanes("fl_e9", 1'b1, 1'b0, 8'hC3, 8'h00);
    step(1'b1, 8'h22); check_lanes("fl_e10", 1'b0, 1'b0, 8'hC3, 8'h00);
    step(1'b0, 8'h00); check_lanes("fl_e11", 1'b0, 1'b0, 8'hC3, 8'h00);
    step(1'b0, 8'h00); check_lanes("fl_e12", 1'b1, 1'b1, 8'h11, 8'h22);

    // 3C, three idle cycles, 4D: below the flush threshold
    do_reset(2, 1'b0, 8'h00);
    step(1'b1, 8'h3C); check_lanes("nf_e1", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00); check_lanes("nf_e2", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00); check_lanes("nf_e3", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00); check_lanes("nf_e4", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h4D); check_lanes("nf_e5", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00); check_lanes("nf_e6", 1'b1, 1'b1, 8'h3C, 8'h4D);
    step(1'b0, 8'h00); check_lanes("nf_e7", 1'b1, 1'b1, 8'h3C, 8'h4D);
    step(1'b0, 8'h00); check_lanes("nf_e8", 1'b0, 1'b0, 8'h3C, 8'h4D);

    // Reset between 01 and 02: 01 is lost, 02 restarts on stripe 0 and is flushed
    do_reset(2, 1'b0, 8'h00);
    step(1'b1, 8'h01); check_lanes("mr_e1", 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    step(1'b0, 8'h00); check_lanes("mr_rst", 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b0;
    step(1'b1, 8'h02); check_lanes("mr_f1", 1'b0, 1'b0, 8'h00, 8'h00);
    for (int j = 2; j <= 5; j++) begin
      step(1'b0, 8'h00);
      check_lanes($sformatf("mr_f%0d", j), 1'b0, 1'b0, 8'h00, 8'h00);
    end
    step(1'b0, 8'h00); check_lanes("mr_f6", 1'b1, 1'b0, 8'h02, 8'h00);
    step(1'b0, 8'h00); check_lanes("mr_f7", 1'b1, 1'b0, 8'h02, 8'h00);
    step(1'b0, 8'h00); check_lanes("mr_f8", 1'b0, 1'b0, 8'h02, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
